pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined datapath. Each cycle it decides whether the PC register, the IF/ID register and the downstream pipeline registers (ID/EX, EX/MEM, MEM/WB) load. It also decides whether IF/ID is flushed or a bubble is injected into ID/EX. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipeline_hazard_controller.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline
//
// Decides each cycle which pipeline registers load, when IF/ID is flushed
// and when a bubble enters ID/EX. Handles load-use hazards, taken-branch
// flushes and multi-cycle data-memory waits. Also counts stall cycles.
//
// Ports:
//   clock, rst          rising-edge clock, asynchronous active-high reset
//   idRs, idRt          source specifiers of the instruction in ID
//   idUsesRt            instruction in ID reads rt
//   exMemRead, exRt     load in EX and its destination register
//   branchTaken         taken branch resolved in ID this cycle
//   memReq, memReady    data-memory access request / completion
//   pcEnable            PC register enable
//   ifidEnable          IF/ID register enable
//   ifidFlush           load NOP into IF/ID
//   idexBubble          load NOP control into ID/EX
//   pipeEnable          enable for ID/EX, EX/MEM, MEM/WB
//   state               RUN=0, FLUSH=1, MEM_WAIT=2
//   stallCycles         saturating count of cycles with pcEnable=0

module pipeline_hazard_controller #(
  parameter int REG_ADDR       = 5,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [REG_ADDR-1:0]  idRs,
  input  logic [REG_ADDR-1:0]  idRt,
  input  logic                 idUsesRt,
  input  logic                 exMemRead,
  input  logic [REG_ADDR-1:0]  exRt,
  input  logic                 branchTaken,
  input  logic                 memReq,
  input  logic                 memReady,
  output logic                 pcEnable,
  output logic                 ifidEnable,
  output logic                 ifidFlush,
  output logic                 idexBubble,
  output logic                 pipeEnable,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Remaining flush cycles after the one issued in RUN.
  localparam logic [1:0] FLUSH_LOAD = 2'(BRANCH_PENALTY - 1);
  localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);

  state_t                 state_q, state_d;
  logic [1:0]             flush_cnt_q, flush_cnt_d;
  logic                   hazard;
  logic                   mem_stall;
  logic                   eval_run;
  logic                   pc_en, ifid_en, ifid_fl, idex_bub, pipe_en;

  assign hazard = exMemRead && (exRt != '0) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  assign mem_stall = memReq && !memReady;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_fl     = 1'b0;
    idex_bub    = 1'b0;
    pipe_en     = 1'b1;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    eval_run    = 1'b0;

    case (state_q)
      FLUSH: begin
        if (mem_stall) begin
          // Freeze holds the counter; the flush resumes afterwards.
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
        end else begin
          // ID holds flushed NOPs, so branch/hazard inputs are ignored here.
          ifid_fl = 1'b1;
          if (flush_cnt_q <= 2'd1) begin
            flush_cnt_d = 2'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (!memReady) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
        end else begin
          // Completion cycle: memReq no longer matters.
          eval_run = 1'b1;
        end
      end
      default: begin
        // RUN, and the unused encoding 3, which recovers as RUN.
        if (mem_stall) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
          state_d = MEM_WAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
    endcase

    if (eval_run) begin
      state_d = RUN;
      if (branchTaken) begin
        // Flush wins over a simultaneous hazard: the dependent instruction is discarded.
        ifid_fl = 1'b1;
        if (MULTI_FLUSH) begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end
      end else if (hazard) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_bub = 1'b1;
      end
    end

    // Reset freezes the whole pipeline so the PC register can self-reset.
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_fl  = 1'b0;
      idex_bub = 1'b0;
      pipe_en  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
      stallCycles <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (!pc_en && (stallCycles != '1)) begin
        stallCycles <= stallCycles + 1'b1;
      end
    end
  end

  assign pcEnable   = pc_en;
  assign ifidEnable = ifid_en;
  assign ifidFlush  = ifid_fl;
  assign idexBubble = idex_bub;
  assign pipeEnable = pipe_en;
  assign state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller

module tb_pipeline_hazard_controller;

  logic       clock = 1'b0;
  logic       rst;
  logic [4:0] idRs, idRt, exRt;
  logic       idUsesRt, exMemRead, branchTaken, memReq, memReady;
  logic       pcEnable, ifidEnable, ifidFlush, idexBubble, pipeEnable;
  logic [1:0] state;
  logic [3:0] stallCycles;

  int tests_run = 0;
  int tests_failed = 0;

  // Control vector order: {pcEnable, ifidEnable, ifidFlush, idexBubble, pipeEnable}
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_FLS = 5'b11101;
  localparam logic [4:0] C_STL = 5'b00011;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
    logic [1:0] st;
    logic [3:0] sc;
  } exp_t;

  exp_t sb[$];

  pipeline_hazard_controller #(
    .REG_ADDR(5),
    .BRANCH_PENALTY(2),
    .CNT_WIDTH(4)
  ) dut (
    .clock(clock),
    .rst(rst),
    .idRs(idRs),
    .idRt(idRt),
    .idUsesRt(idUsesRt),
    .exMemRead(exMemRead),
    .exRt(exRt),
    .branchTaken(branchTaken),
    .memReq(memReq),
    .memReady(memReady),
    .pcEnable(pcEnable),
    .ifidEnable(ifidEnable),
    .ifidFlush(ifidFlush),
    .idexBubble(idexBubble),
    .pipeEnable(pipeEnable),
    .state(state),
    .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic mrd, input logic [4:0] ert, input logic br,
                     input logic mq, input logic my);
    idRs = rs; idRt = rt; idUsesRt = uses; exMemRead = mrd; exRt = ert;
    branchTaken = br; memReq = mq; memReady = my;
  endtask

  task automatic quiet();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs were driven at the negedge; push the expectation, sample 2 time
  // units later (well before the posedge), then advance to the next negedge.
  task automatic cyc(input string tag, input logic [4:0] ctl, input logic [1:0] st,
                     input logic [3:0] sc);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.st = st; e.sc = sc;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check({e.tag, ".ctl"}, {27'd0, pcEnable, ifidEnable, ifidFlush, idexBubble, pipeEnable},
          {27'd0, e.ctl});
    check({e.tag, ".state"}, {30'd0, state}, {30'd0, e.st});
    check({e.tag, ".stall"}, {28'd0, stallCycles}, {28'd0, e.sc});
    @(negedge clock);
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    @(negedge clock);

    // Reset with branch and memory request active
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("rst0", C_FRZ, 2'd0, 4'd0);
    cyc("rst1", C_FRZ, 2'd0, 4'd0);
    rst = 1'b0; quiet();
    cyc("rel", C_RUN, 2'd0, 4'd0);

    // Load-use hazard
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs", C_STL, 2'd0, 4'd0);
    quiet();
    cyc("lu_after", C_RUN, 2'd0, 4'd1);
    drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lu_r0", C_RUN, 2'd0, 4'd1);
    drv(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_unused", C_RUN, 2'd0, 4'd1);
    drv(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_used", C_STL, 2'd0, 4'd1);
    // Back-to-back dependent loads
    drv(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("b2b_0", C_STL, 2'd0, 4'd2);
    drv(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    cyc("b2b_1", C_STL, 2'd0, 4'd3);
    quiet();
    cyc("b2b_end", C_RUN, 2'd0, 4'd4);

    // Taken branch, penalty 2
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("br_0", C_FLS, 2'd0, 4'd4);
    quiet();
    cyc("br_1", C_FLS, 2'd1, 4'd4);
    cyc("br_end", C_RUN, 2'd0, 4'd4);

    // Branch with hazard: flush only, hazard ignored inside FLUSH
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc("brhz_0", C_FLS, 2'd0, 4'd4);
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc("brhz_1", C_FLS, 2'd1, 4'd4);
    quiet();
    cyc("brhz_end", C_RUN, 2'd0, 4'd4);

    // Clear counter, then a 3-cycle memory wait
    rst = 1'b1;
    cyc("rst2", C_FRZ, 2'd0, 4'd0);
    rst = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("mw_0", C_FRZ, 2'd0, 4'd0);
    cyc("mw_1", C_FRZ, 2'd2, 4'd1);
    cyc("mw_2", C_FRZ, 2'd2, 4'd2);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("mw_rdy", C_RUN, 2'd2, 4'd3);
    quiet();
    cyc("mw_end", C_RUN, 2'd0, 4'd3);

    // Memory wait with branch: freeze first, flush on the ready cycle
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cyc("mwbr_0", C_FRZ, 2'd0, 4'd3);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    cyc("mwbr_rdy", C_FLS, 2'd2, 4'd4);
    quiet();
    cyc("mwbr_fl", C_FLS, 2'd1, 4'd4);
    cyc("mwbr_end", C_RUN, 2'd0, 4'd4);

    // Freeze inside FLUSH extends the flush
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("flfz_0", C_FLS, 2'd0, 4'd4);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("flfz_frz", C_FRZ, 2'd1, 4'd4);
    quiet();
    cyc("flfz_fl", C_FLS, 2'd1, 4'd5);
    cyc("flfz_end", C_RUN, 2'd0, 4'd5);

    // Memory wait with hazard: bubble on the ready cycle
    drv(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
    cyc("mwhz_0", C_FRZ, 2'd0, 4'd5);
    drv(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1);
    cyc("mwhz_rdy", C_STL, 2'd2, 4'd6);
    quiet();
    cyc("mwhz_end", C_RUN, 2'd0, 4'd7);

    // Reset mid-FLUSH discards the pending flush
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("rf_0", C_FLS, 2'd0, 4'd7);
    quiet();
    rst = 1'b1;
    cyc("rf_rst", C_FRZ, 2'd0, 4'd0);
    rst = 1'b0;
    cyc("rf_rel", C_RUN, 2'd0, 4'd0);

    // Saturation over a 20-cycle memory wait
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat_%0d", i), C_FRZ, (i == 0) ? 2'd0 : 2'd2,
          (i > 15) ? 4'd15 : 4'(i));
    end
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("sat_rdy", C_RUN, 2'd2, 4'd15);
    quiet();
    cyc("sat_end", C_RUN, 2'd0, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
